// File: rtl/baud_detect_pkg.sv
// Shared definitions for the autobaud detector: rate codes, FSM states and
// the start-bit width bounds that separate the supported baud rates.
package baud_detect_pkg;

    // Codes match the baud generator's prescaler select decode.
    localparam logic [1:0] SEL_9600   = 2'd0;
    localparam logic [1:0] SEL_57600  = 2'd1;
    localparam logic [1:0] SEL_115200 = 2'd2;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_MEASURE,
        ST_CLASSIFY,
        ST_LOCKED
    } state_t;

    function automatic int bit_period(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int bound_min(input int clk_freq);
        return bit_period(clk_freq, 115200) / 2;
    endfunction

    function automatic int bound_hi(input int clk_freq);
        return (bit_period(clk_freq, 115200) + bit_period(clk_freq, 57600)) / 2;
    endfunction

    function automatic int bound_lo(input int clk_freq);
        return (bit_period(clk_freq, 57600) + bit_period(clk_freq, 9600)) / 2;
    endfunction

    function automatic int bound_max(input int clk_freq);
        return bit_period(clk_freq, 9600) * 3 / 2;
    endfunction

endpackage

// File: rtl/baud_detect_rx_sync.sv
// Multi-stage rx synchronizer, idle-high after reset, with edge strobes and a
// primed flag that marks when the synchronized value reflects the real line.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic src_clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall,
    output logic rise,
    output logic primed
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] primed_reg;
    logic                   prev_reg;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '1;
            primed_reg <= '0;
            prev_reg   <= 1'b1;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], rx};
            primed_reg <= {primed_reg[SYNC_STAGES-2:0], 1'b1};
            prev_reg   <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rx_s   = sync_reg[SYNC_STAGES-1];
    assign fall   = prev_reg & ~rx_s;
    assign rise   = ~prev_reg & rx_s;
    // The reset-forced ones must be flushed before a high level can arm the FSM.
    assign primed = primed_reg[SYNC_STAGES-1];

endmodule

// File: rtl/baud_detect.sv
// Autobaud detector: times the start-bit low pulse of a 0x55 training
// character and locks a prescaler select code after repeated agreement.
module baud_detect
    import baud_detect_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int MATCH_COUNT = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       detect,
    output logic [1:0] Prescaler_sel,
    output logic       locked,
    output logic       err
);

    localparam int MIN_W  = bound_min(CLK_FREQ);
    localparam int B_HI_W = bound_hi(CLK_FREQ);
    localparam int B_LO_W = bound_lo(CLK_FREQ);
    localparam int MAX_W  = bound_max(CLK_FREQ);
    localparam int CW     = $clog2(MAX_W + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_W + 1);

    logic rx_s, fall, rise, primed;

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall),
        .rise    (rise),
        .primed  (primed)
    );

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   width_reg, width_next;
    logic [2:0]      match_reg, match_next, match_new;
    logic [1:0]      cand_reg, cand_next;
    logic [1:0]      sel_reg, sel_next;
    logic            locked_reg, locked_next;
    logic            err_reg, err_next;
    logic [1:0]      code;
    logic            code_ok;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_ARM;
            cnt_reg    <= '0;
            width_reg  <= '0;
            match_reg  <= '0;
            cand_reg   <= SEL_9600;
            sel_reg    <= SEL_9600;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            width_reg  <= width_next;
            match_reg  <= match_next;
            cand_reg   <= cand_next;
            sel_reg    <= sel_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        code    = SEL_9600;
        code_ok = 1'b1;
        if (width_reg < CW'(MIN_W) || width_reg > CW'(MAX_W))
            code_ok = 1'b0;
        else if (width_reg < CW'(B_HI_W))
            code = SEL_115200;
        else if (width_reg < CW'(B_LO_W))
            code = SEL_57600;
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        width_next  = width_reg;
        match_next  = match_reg;
        match_new   = match_reg;
        cand_next   = cand_reg;
        sel_next    = sel_reg;
        locked_next = locked_reg;
        err_next    = 1'b0;

        // detect overrides every other event in the same cycle.
        if (detect) begin
            state_next  = ST_ARM;
            locked_next = 1'b0;
            match_next  = '0;
        end else begin
            case (state_reg)
                ST_ARM: begin
                    if (rx_s && primed)
                        state_next = ST_IDLE;
                end
                ST_IDLE: begin
                    if (fall) begin
                        cnt_next   = CW'(1);
                        state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        width_next = cnt_reg;
                        state_next = ST_CLASSIFY;
                    end else if (cnt_reg == CNT_SAT) begin
                        err_next   = 1'b1;
                        match_next = '0;
                        state_next = ST_ARM;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_CLASSIFY: begin
                    if (!code_ok) begin
                        err_next   = 1'b1;
                        match_next = '0;
                        state_next = ST_IDLE;
                    end else begin
                        if (code == cand_reg) begin
                            match_new = match_reg + 3'd1;
                        end else begin
                            match_new = 3'd1;
                            cand_next = code;
                        end
                        match_next = match_new;
                        if (match_new == 3'(MATCH_COUNT)) begin
                            sel_next    = code;
                            locked_next = 1'b1;
                            state_next  = ST_LOCKED;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_LOCKED: ;
                default: state_next = ST_ARM;
            endcase
        end
    end

    assign Prescaler_sel = sel_reg;
    assign locked        = locked_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_baud_detect.sv
// Directed bench for baud_detect: training pulses of known width with
// hand-computed rate codes, lock timing, error pulses and reset behaviour.
module tb_baud_detect;

    logic       src_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       detect  = 1'b0;
    logic [1:0] Prescaler_sel;
    logic       locked;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;
    int err_cycles = 0;
    int err_edges  = 0;
    int clash      = 0;
    int e0;
    logic err_q = 1'b0;

    baud_detect dut (
        .src_clk       (src_clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .detect        (detect),
        .Prescaler_sel (Prescaler_sel),
        .locked        (locked),
        .err           (err)
    );

    always #5 src_clk = ~src_clk;

    always @(negedge src_clk) begin
        if (err) err_cycles++;
        if (err && !err_q) err_edges++;
        if (err && locked) clash++;
        err_q = err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge src_clk);
    endtask

    task automatic low(input int n);
        rx = 1'b0;
        repeat (n) @(negedge src_clk);
        rx = 1'b1;
    endtask

    task automatic pulse_nolock(input string tag, input int n);
        low(n);
        gap(434);
        check({tag, "_unlocked"}, 32'(locked), 0);
    endtask

    // Lock must appear exactly on the 4th clock after rx is driven high.
    task automatic pulse_lock(input string tag, input int n, input logic [1:0] exp_sel);
        low(n);
        gap(3);
        check({tag, "_early"}, 32'(locked), 0);
        gap(1);
        check({tag, "_locked"}, 32'(locked), 1);
        check({tag, "_sel"}, 32'(Prescaler_sel), 32'(exp_sel));
        gap(434);
    endtask

    task automatic do_detect(input string tag, input logic [1:0] keep_sel);
        detect = 1'b1;
        @(negedge src_clk);
        detect = 1'b0;
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_sel"}, 32'(Prescaler_sel), 32'(keep_sel));
        gap(20);
    endtask

    initial begin
        gap(3);
        check("rst_sel", 32'(Prescaler_sel), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        gap(10);

        e0 = err_cycles;
        pulse_nolock("t1_p1", 434);
        pulse_lock("t1", 434, 2'd2);
        check("t1_no_err", 32'(err_cycles - e0), 0);

        do_detect("t2_det_a", 2'd2);
        pulse_nolock("t2_p1", 868);
        pulse_lock("t2_57k", 868, 2'd1);
        do_detect("t2_det_b", 2'd1);
        pulse_nolock("t2_p3", 5208);
        pulse_lock("t2_9k6", 5208, 2'd0);
        do_detect("t2_det_c", 2'd0);

        pulse_nolock("t3_p1", 434);
        pulse_nolock("t3_p2", 868);
        pulse_lock("t3", 868, 2'd1);
        do_detect("t3_det", 2'd1);

        e0 = err_edges;
        begin
            int c0;
            c0 = err_cycles;
            low(100);
            gap(434);
            check("t4_err_cycles", 32'(err_cycles - c0), 1);
        end
        check("t4_err_pulses", 32'(err_edges - e0), 1);
        check("t4_unlocked", 32'(locked), 0);
        pulse_nolock("t4_p1", 434);
        pulse_lock("t4", 434, 2'd2);
        do_detect("t4_det", 2'd2);

        e0 = err_cycles;
        rx = 1'b0;
        gap(8000);
        check("t5_timeout_err", 32'(err_cycles - e0), 1);
        check("t5_unlocked", 32'(locked), 0);
        rx = 1'b1;
        gap(434);
        check("t5_no_extra_err", 32'(err_cycles - e0), 1);
        pulse_nolock("t5_p1", 434);
        pulse_lock("t5", 434, 2'd2);
        do_detect("t5_det", 2'd2);

        rx = 1'b0;
        gap(200);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_sel", 32'(Prescaler_sel), 0);
        check("t6_async_locked", 32'(locked), 0);
        check("t6_async_err", 32'(err), 0);
        gap(3);
        rst_n = 1'b1;
        e0 = err_cycles;
        gap(700);
        rx = 1'b1;
        gap(434);
        check("t6_unlocked", 32'(locked), 0);
        check("t6_no_err", 32'(err_cycles - e0), 0);
        pulse_nolock("t6_p1", 868);
        pulse_lock("t6", 868, 2'd1);

        check("err_one_cycle", 32'(err_cycles), 32'(err_edges));
        check("err_lock_clash", 32'(clash), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
